// File: rtl/chart_pkg.sv
// Shared definitions for the 4-lane chart memory, used by both the recorder
// (writer) and the chart player (reader).
//   ADDR_WIDTH / DATA_WIDTH : chart RAM geometry (one bit per lane per row)
//   MAX_ADDR                : last writable row address
//   FIRST_ADDR              : first row of a chart; row 0 is never played
//   TICK_DIV                : clk cycles per row (100 MHz -> 10 ms rows)
//   state_t                 : recorder state encoding
package chart_pkg;

  localparam int ADDR_WIDTH = 11;
  localparam int DATA_WIDTH = 4;
  localparam int MAX_ADDR   = 2000;
  localparam int FIRST_ADDR = 1;
  localparam int TICK_DIV   = 1000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/key_edge_sync.sv
// Per-lane key conditioning: 2-flop synchronizer followed by a rising-edge
// detector.
//   clk, rst : system clock, asynchronous active-high reset (clears all flops)
//   keys     : raw asynchronous lane keys, 1 = pressed
//   onset    : one-cycle pulse per lane on a synchronized 0->1 transition;
//              valid two cycles after the key change, so the consumer
//              registers it on the third edge
module key_edge_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] keys,
  output logic [WIDTH-1:0] onset
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign onset = sync2 & ~prev;

endmodule

// File: rtl/chart_recorder.sv
// Chart recorder: records live key onsets into port A of the chart RAM, one
// row per tick starting at FIRST_ADDR, in the format the chart player reads.
//   clk, rst   : system clock, asynchronous active-high reset
//   start      : pulse; begin a new recording at FIRST_ADDR (also restarts)
//   stop       : pulse; end recording, partial row discarded
//   keys       : raw asynchronous lane keys
//   ena, wea   : RAM port enable / write enable, one-cycle pulse per row
//   addra      : RAM write address (holds between writes)
//   dina       : RAM write data, lane onset bits of the row
//   recording  : high while recording
//   done       : high once a recording has ended
//   length     : rows written in the current or last recording
module chart_recorder #(
  parameter int ADDR_WIDTH = chart_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = chart_pkg::DATA_WIDTH,
  parameter int MAX_ADDR   = chart_pkg::MAX_ADDR,
  parameter int TICK_DIV   = chart_pkg::TICK_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [DATA_WIDTH-1:0] keys,
  output logic                  ena,
  output logic                  wea,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [DATA_WIDTH-1:0] dina,
  output logic                  recording,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] length
);

  import chart_pkg::*;

  localparam int                  CNT_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]      TICK_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = ADDR_WIDTH'(FIRST_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(MAX_ADDR);

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      tick_cnt;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] onset;
  logic                  tick;
  logic                  wr_row;

  key_edge_sync #(
    .WIDTH (DATA_WIDTH)
  ) u_keys (
    .clk   (clk),
    .rst   (rst),
    .keys  (keys),
    .onset (onset)
  );

  // Last cycle of a row. A start on this cycle wins and the row is dropped;
  // a stop on this cycle still lets the row be written.
  assign tick   = (state == RECORD) && (tick_cnt == TICK_LAST);
  assign wr_row = tick && !start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = RECORD;
        end
      end
      RECORD: begin
        if (start) begin
          state_nxt = RECORD;
        end else if (stop) begin
          state_nxt = DONE;
        end else if (tick && (wr_addr == ADDR_LAST)) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    recording = (state == RECORD);
    done      = (state == DONE);
  end

  // Datapath. The onset arriving on the tick cycle is OR-ed straight into
  // the written row rather than into the accumulator being cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      wr_addr  <= '0;
      acc      <= '0;
      length   <= '0;
      wea      <= 1'b0;
      addra    <= '0;
      dina     <= '0;
    end else begin
      wea <= wr_row;
      if (start) begin
        tick_cnt <= '0;
        wr_addr  <= ADDR_FIRST;
        acc      <= '0;
        length   <= '0;
      end else if (state == RECORD) begin
        if (tick) begin
          tick_cnt <= '0;
          addra    <= wr_addr;
          dina     <= acc | onset;
          acc      <= '0;
          wr_addr  <= wr_addr + 1'b1;
          length   <= length + 1'b1;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
          acc      <= acc | onset;
        end
      end
    end
  end

  assign ena = wea;

endmodule

// File: tb/tb_chart_recorder.sv
module tb_chart_recorder;

  localparam int T    = 4;
  localparam int MAXA = 8;
  localparam int AW   = 11;
  localparam int DW   = 4;
  localparam int HN   = 8192;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [DW-1:0] keys = '0;
  logic          ena, wea, recording, done;
  logic [AW-1:0] addra, length;
  logic [DW-1:0] dina;

  chart_recorder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_ADDR   (MAXA),
    .TICK_DIV   (T)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .keys      (keys),
    .ena       (ena),
    .wea       (wea),
    .addra     (addra),
    .dina      (dina),
    .recording (recording),
    .done      (done),
    .length    (length)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Input history indexed by the clock edge that samples it.
  logic [DW-1:0] kh [HN];
  bit            sh [HN];
  bit            ph [HN];
  bit            rh [HN];

  typedef struct {
    int e;
    int a;
    int d;
    bit en;
  } wr_t;

  wr_t act_q[$];
  wr_t got_q[$];
  wr_t exp_q[$];
  int  exp_len;
  bit  exp_done;
  bit  exp_rec;

  always @(posedge clk) begin
    if (cyc < HN) begin
      kh[cyc] = keys;
      sh[cyc] = start;
      ph[cyc] = stop;
      rh[cyc] = rst;
    end
    cyc = cyc + 1;
  end

  always @(posedge clk) begin
    #1;
    if (wea === 1'b1) act_q.push_back('{cyc - 1, int'(addra), int'(dina), ena});
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Lanes whose key went 0->1 get credited to the row containing edge e,
  // two edges after the edge that first sampled the press.
  function automatic logic [DW-1:0] onset_at(input int e);
    logic [DW-1:0] now_k = '0;
    logic [DW-1:0] before_k = '0;
    if (e - 2 >= 0) now_k = kh[e-2];
    if (e - 3 >= 0) before_k = kh[e-3];
    return now_k & ~before_k;
  endfunction

  // Expected writes and final status for edges [w0, w1), from the recording
  // rules: row r of a recording started at edge s collects onsets on edges
  // (s+(r-1)T, s+rT] and is written at edge s+rT with address r.
  function automatic void predict(input int w0, input int w1);
    exp_q.delete();
    exp_len = 0;
    exp_done = 0;
    exp_rec = 0;
    for (int s = w0; s < w1; s++) begin
      if (sh[s] && !rh[s]) begin
        int term = w1;
        int kind = 0;
        int rows = 0;
        for (int e = s + 1; e < w1 && kind == 0; e++) begin
          if (rh[e]) begin kind = 3; term = e; end
          else if (sh[e]) begin kind = 2; term = e; end
          else if (ph[e]) begin kind = 1; term = e; end
        end
        for (int r = 1; r <= MAXA; r++) begin
          int fin = s + r * T;
          logic [DW-1:0] d = '0;
          if (fin >= w1 || fin > term || (fin == term && kind != 1)) break;
          for (int e = fin - T + 1; e <= fin; e++) d |= onset_at(e);
          exp_q.push_back('{fin, r, int'(d), 1'b1});
          rows = r;
        end
        exp_len  = (kind == 3) ? 0 : rows;
        exp_rec  = (kind == 0) && (rows < MAXA);
        exp_done = (kind == 1) || (kind != 3 && rows == MAXA);
      end
    end
  endfunction

  function automatic void collect(input int w0, input int w1);
    got_q.delete();
    foreach (act_q[i]) if (act_q[i].e >= w0 && act_q[i].e < w1) got_q.push_back(act_q[i]);
  endfunction

  task automatic do_reset();
    keys = '0;
    start = 1'b0;
    stop = 1'b0;
    step(3);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    int s;
    int w;
    step(2);
    checks++;
    if ({wea, ena, recording, done, addra, dina, length} !== '0) begin
      failures++;
      $display("FAIL reset_init: got wea=%0b ena=%0b rec=%0b done=%0b addra=%0d dina=%h len=%0d, expected all 0",
               wea, ena, recording, done, addra, dina, length);
    end
    rst = 1'b0;
    step(1);
    s = cyc;
    start = 1'b1;
    step(1);
    start = 1'b0;
    keys = 4'b1000;
    while (cyc < s + T + 2) step(1);
    keys = '0;
    step(3);
    rst = 1'b1;
    #1;
    checks++;
    if ({wea, ena, recording, done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_async_ctl: got wea=%0b ena=%0b rec=%0b done=%0b, expected 0000", wea, ena, recording, done);
    end
    checks++;
    if ({addra, dina, length} !== '0) begin
      failures++;
      $display("FAIL reset_async_data: got addra=%0d dina=%h len=%0d, expected 0 0 0", addra, dina, length);
    end
    step(2);
    rst = 1'b0;
    step(1);
    w = cyc;
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(2 * T);
    collect(w, cyc);
    checks++;
    if (got_q.size() != 0 || recording !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL idle_stop: got writes=%0d rec=%0b done=%0b, expected 0 0 0", got_q.size(), recording, done);
    end
  endtask

  task automatic test_single_onset();
    int w0;
    do_reset();
    w0 = cyc;
    start = 1'b1;
    step(1);
    start = 1'b0;
    keys = 4'b0001;
    step(4);
    keys = '0;
    step(3 * T);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(2);
    predict(w0, cyc);
    collect(w0, cyc);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL single_count: got %0d writes, expected %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i].e !== exp_q[i].e || got_q[i].a !== exp_q[i].a || got_q[i].d !== exp_q[i].d || got_q[i].en !== 1'b1) begin
        failures++;
        $display("FAIL single_row%0d: got edge=%0d addra=%0d dina=%h ena=%0b, expected edge=%0d addra=%0d dina=%h ena=1",
                 i, got_q[i].e, got_q[i].a, got_q[i].d, got_q[i].en, exp_q[i].e, exp_q[i].a, exp_q[i].d);
      end
    end
    checks++;
    if ({length, done, recording} !== {AW'(exp_len), exp_done, exp_rec}) begin
      failures++;
      $display("FAIL single_status: got len=%0d done=%0b rec=%0b, expected len=%0d done=%0b rec=%0b",
               length, done, recording, exp_len, exp_done, exp_rec);
    end
  endtask

  task automatic test_held_key();
    int w0;
    int s;
    do_reset();
    w0 = cyc;
    s = cyc;
    start = 1'b1;
    step(1);
    start = 1'b0;
    keys = 4'b0100;
    step(3 * T);
    keys = '0;
    // press lands on the last cycle of row 5
    while (cyc < s + 5 * T - 2) step(1);
    keys = 4'b0010;
    step(2);
    keys = '0;
    while (cyc < s + 6 * T + 1) step(1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(2);
    predict(w0, cyc);
    collect(w0, cyc);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL held_count: got %0d writes, expected %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i].e !== exp_q[i].e || got_q[i].a !== exp_q[i].a || got_q[i].d !== exp_q[i].d || got_q[i].en !== 1'b1) begin
        failures++;
        $display("FAIL held_row%0d: got edge=%0d addra=%0d dina=%h ena=%0b, expected edge=%0d addra=%0d dina=%h ena=1",
                 i, got_q[i].e, got_q[i].a, got_q[i].d, got_q[i].en, exp_q[i].e, exp_q[i].a, exp_q[i].d);
      end
    end
    checks++;
    if ({length, done, recording} !== {AW'(exp_len), exp_done, exp_rec}) begin
      failures++;
      $display("FAIL held_status: got len=%0d done=%0b rec=%0b, expected len=%0d done=%0b rec=%0b",
               length, done, recording, exp_len, exp_done, exp_rec);
    end
  endtask

  task automatic test_full_run();
    int w0;
    int k;
    do_reset();
    w0 = cyc;
    start = 1'b1;
    step(1);
    start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 80) begin
      if ($urandom_range(0, 2) == 0) keys = 4'($urandom_range(0, 15));
      step(1);
      k++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL full_timeout: got done=%0b after %0d cycles, expected 1", done, k);
    end
    keys = '0;
    step(3 * T);
    predict(w0, cyc);
    collect(w0, cyc);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL full_count: got %0d writes, expected %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i].e !== exp_q[i].e || got_q[i].a !== exp_q[i].a || got_q[i].d !== exp_q[i].d || got_q[i].en !== 1'b1) begin
        failures++;
        $display("FAIL full_row%0d: got edge=%0d addra=%0d dina=%h ena=%0b, expected edge=%0d addra=%0d dina=%h ena=1",
                 i, got_q[i].e, got_q[i].a, got_q[i].d, got_q[i].en, exp_q[i].e, exp_q[i].a, exp_q[i].d);
      end
    end
    checks++;
    if ({length, done, recording} !== {AW'(exp_len), exp_done, exp_rec}) begin
      failures++;
      $display("FAIL full_status: got len=%0d done=%0b rec=%0b, expected len=%0d done=%0b rec=%0b",
               length, done, recording, exp_len, exp_done, exp_rec);
    end
  endtask

  task automatic test_stop();
    int w0;
    int s;
    do_reset();
    w0 = cyc;
    s = cyc;
    start = 1'b1;
    step(1);
    start = 1'b0;
    keys = 4'b0011;
    step(2);
    keys = '0;
    while (cyc < s + 2 * T + 2) step(1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    checks++;
    if ({length, done, recording} !== {AW'(2), 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL stop_mid_status: got len=%0d done=%0b rec=%0b, expected len=2 done=1 rec=0", length, done, recording);
    end
    step(T);
    s = cyc;
    start = 1'b1;
    step(1);
    start = 1'b0;
    while (cyc < s + 3 * T) step(1);
    keys = 4'b1001;
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    keys = '0;
    step(2 * T);
    predict(w0, cyc);
    collect(w0, cyc);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL stop_count: got %0d writes, expected %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i].e !== exp_q[i].e || got_q[i].a !== exp_q[i].a || got_q[i].d !== exp_q[i].d || got_q[i].en !== 1'b1) begin
        failures++;
        $display("FAIL stop_row%0d: got edge=%0d addra=%0d dina=%h ena=%0b, expected edge=%0d addra=%0d dina=%h ena=1",
                 i, got_q[i].e, got_q[i].a, got_q[i].d, got_q[i].en, exp_q[i].e, exp_q[i].a, exp_q[i].d);
      end
    end
    checks++;
    if ({length, done, recording} !== {AW'(exp_len), exp_done, exp_rec}) begin
      failures++;
      $display("FAIL stop_status: got len=%0d done=%0b rec=%0b, expected len=%0d done=%0b rec=%0b",
               length, done, recording, exp_len, exp_done, exp_rec);
    end
  endtask

  task automatic test_restart();
    int w0;
    int s;
    int k;
    do_reset();
    w0 = cyc;
    s = cyc;
    start = 1'b1;
    step(1);
    start = 1'b0;
    keys = 4'b0101;
    step(1);
    keys = '0;
    while (cyc < s + 2 * T + 1) step(1);
    keys = 4'b1010;
    start = 1'b1;
    step(1);
    start = 1'b0;
    checks++;
    if ({length, recording} !== {AW'(0), 1'b1}) begin
      failures++;
      $display("FAIL restart_len: got len=%0d rec=%0b, expected len=0 rec=1", length, recording);
    end
    step(2 * T + 1);
    keys = '0;
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(2);
    start = 1'b1;
    step(1);
    start = 1'b0;
    keys = 4'b0110;
    step(T + 1);
    keys = '0;
    predict(w0, cyc);
    collect(w0, cyc);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL restart_count: got %0d writes, expected %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i].e !== exp_q[i].e || got_q[i].a !== exp_q[i].a || got_q[i].d !== exp_q[i].d || got_q[i].en !== 1'b1) begin
        failures++;
        $display("FAIL restart_row%0d: got edge=%0d addra=%0d dina=%h ena=%0b, expected edge=%0d addra=%0d dina=%h ena=1",
                 i, got_q[i].e, got_q[i].a, got_q[i].d, got_q[i].en, exp_q[i].e, exp_q[i].a, exp_q[i].d);
      end
    end
    checks++;
    if ({length, done, recording} !== {AW'(exp_len), exp_done, exp_rec}) begin
      failures++;
      $display("FAIL restart_status: got len=%0d done=%0b rec=%0b, expected len=%0d done=%0b rec=%0b",
               length, done, recording, exp_len, exp_done, exp_rec);
    end
    k = 0;
    while (wea !== 1'b1 && k < 4 * T) begin
      step(1);
      k++;
    end
    checks++;
    if (wea !== 1'b1) begin
      failures++;
      $display("FAIL rst_on_wea_wait: got wea=%0b after %0d cycles, expected 1", wea, k);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({wea, ena, length} !== '0) begin
      failures++;
      $display("FAIL rst_on_wea: got wea=%0b ena=%0b len=%0d, expected 0 0 0", wea, ena, length);
    end
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_random();
    int w0;
    int r;
    for (int round = 0; round < 3; round++) begin
      do_reset();
      w0 = cyc;
      for (int c = 0; c < 160; c++) begin
        if ($urandom_range(0, 3) == 0) keys = 4'($urandom_range(0, 15));
        r = $urandom_range(0, 49);
        start = (r == 0) || (c == 2);
        stop = (r == 1) && (c != 2);
        step(1);
      end
      start = 1'b0;
      stop = 1'b0;
      keys = '0;
      step(2);
      predict(w0, cyc);
      collect(w0, cyc);
      checks++;
      if (got_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL rand%0d_count: got %0d writes, expected %0d", round, got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        checks++;
        if (got_q[i].e !== exp_q[i].e || got_q[i].a !== exp_q[i].a || got_q[i].d !== exp_q[i].d || got_q[i].en !== 1'b1) begin
          failures++;
          $display("FAIL rand%0d_row%0d: got edge=%0d addra=%0d dina=%h ena=%0b, expected edge=%0d addra=%0d dina=%h ena=1",
                   round, i, got_q[i].e, got_q[i].a, got_q[i].d, got_q[i].en, exp_q[i].e, exp_q[i].a, exp_q[i].d);
        end
      end
      checks++;
      if ({length, done, recording} !== {AW'(exp_len), exp_done, exp_rec}) begin
        failures++;
        $display("FAIL rand%0d_status: got len=%0d done=%0b rec=%0b, expected len=%0d done=%0b rec=%0b",
                 round, length, done, recording, exp_len, exp_done, exp_rec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_onset();
    test_held_key();
    test_full_run();
    test_stop();
    test_restart();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
